// File: rtl/axi_sram_slave.sv
// AXI4 slave bridging single-outstanding INCR bursts onto a single-port synchronous SRAM macro.
// Read data from the macro arrives one cycle after CS&OE, so each read beat takes three cycles.
module axi_sram_slave #(
  parameter int IDW = 8
) (
  input  logic           clk,
  input  logic           rst,
  // write address channel
  input  logic [IDW-1:0] AWID,
  input  logic [31:0]    AWADDR,
  input  logic [3:0]     AWLEN,
  input  logic           AWVALID,
  output logic           AWREADY,
  // write data channel
  input  logic [31:0]    WDATA,
  input  logic [3:0]     WSTRB,
  input  logic           WLAST,
  input  logic           WVALID,
  output logic           WREADY,
  // write response channel
  output logic [IDW-1:0] BID,
  output logic [1:0]     BRESP,
  output logic           BVALID,
  input  logic           BREADY,
  // read address channel
  input  logic [IDW-1:0] ARID,
  input  logic [31:0]    ARADDR,
  input  logic [3:0]     ARLEN,
  input  logic           ARVALID,
  output logic           ARREADY,
  // read data channel
  output logic [IDW-1:0] RID,
  output logic [31:0]    RDATA,
  output logic [1:0]     RRESP,
  output logic           RLAST,
  output logic           RVALID,
  input  logic           RREADY,
  // SRAM macro side
  output logic           CS,
  output logic           OE,
  output logic [3:0]     WEB,
  output logic [13:0]    A,
  output logic [31:0]    DI,
  input  logic [31:0]    DO
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    BRSP,
    RD_ADDR,
    RD_WAIT,
    RD_DATA
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t         state;
  logic [IDW-1:0] id_q;
  logic [13:0]    addr_q;
  logic [3:0]     len_q;
  logic [3:0]     cnt_q;
  logic           ovf_q;
  logic [13:0]    a_hold;
  logic [31:0]    di_hold;
  logic [31:0]    rdata_q;
  logic [1:0]     bresp_q;
  logic           bvalid_q;
  logic           rvalid_q;
  logic           rlast_q;

  logic aw_fire;
  logic ar_fire;
  logic wr_fire;
  logic rd_fire;

  // Only word address bits [15:2] reach the macro.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR[31:16], AWADDR[1:0], ARADDR[31:16], ARADDR[1:0]};

  // Ready signals are decoded from state; write address wins over read in IDLE.
  assign AWREADY = !rst && (state == IDLE);
  assign ARREADY = !rst && (state == IDLE) && !AWVALID;
  assign WREADY  = !rst && (state == WR);

  assign aw_fire = AWREADY && AWVALID;
  assign ar_fire = ARREADY && ARVALID;
  assign wr_fire = WREADY && WVALID;
  assign rd_fire = !rst && (state == RD_ADDR);

  assign BID    = id_q;
  assign BRESP  = bresp_q;
  assign BVALID = bvalid_q;
  assign RID    = id_q;
  assign RDATA  = rdata_q;
  assign RRESP  = RESP_OKAY;
  assign RLAST  = rlast_q;
  assign RVALID = rvalid_q;

  // Macro strobes fire in the same cycle as the W handshake or the RD_ADDR state;
  // between accesses the address and data buses keep their last driven value.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    CS  = wr_fire || rd_fire;
    OE  = rd_fire;
    WEB = 4'hF;
    A   = a_hold;
    DI  = di_hold;
    if (wr_fire) begin
      WEB = ~WSTRB;
      A   = addr_q;
      DI  = WDATA;
    end else if (rd_fire) begin
      A = addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_hold  <= '0;
      di_hold <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      if (wr_fire || rd_fire) a_hold <= addr_q;
      if (wr_fire) di_hold <= WDATA;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rdata_q  <= '0;
      bresp_q  <= RESP_OKAY;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_fire) begin
            id_q   <= AWID;
            addr_q <= AWADDR[15:2];
            len_q  <= AWLEN;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            state  <= WR;
          end else if (ar_fire) begin
            id_q   <= ARID;
            addr_q <= ARADDR[15:2];
            len_q  <= ARLEN;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            state  <= RD_ADDR;
          end
        end

        WR: begin
          if (wr_fire) begin
            addr_q <= addr_q + 14'd1;
            cnt_q  <= cnt_q + 4'd1;
            if (WLAST) begin
              // cnt_q counts beats before this one; ovf_q covers bursts longer than 16.
              bresp_q  <= (ovf_q || (cnt_q != len_q)) ? RESP_SLVERR : RESP_OKAY;
              bvalid_q <= 1'b1;
              state    <= BRSP;
            end else if (cnt_q == len_q) begin
              ovf_q <= 1'b1;
            end
          end
        end

        BRSP: begin
          if (BREADY) begin
            bvalid_q <= 1'b0;
            state    <= IDLE;
          end
        end

        RD_ADDR: state <= RD_WAIT;

        RD_WAIT: begin
          rdata_q  <= DO;
          rvalid_q <= 1'b1;
          rlast_q  <= (cnt_q == len_q);
          state    <= RD_DATA;
        end

        RD_DATA: begin
          if (RREADY) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              state <= IDLE;
            end else begin
              addr_q <= addr_q + 14'd1;
              cnt_q  <= cnt_q + 4'd1;
              state  <= RD_ADDR;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: behavioural SRAM macro, reference memory, and
// B/R scoreboards filled when stimulus is driven and drained when the DUT responds.
module tb_axi_sram_slave;

  localparam int IDW = 8;
  localparam int TMO = 50;

  logic           clk = 1'b0;
  logic           rst;
  logic [IDW-1:0] AWID;
  logic [31:0]    AWADDR;
  logic [3:0]     AWLEN;
  logic           AWVALID;
  logic           AWREADY;
  logic [31:0]    WDATA;
  logic [3:0]     WSTRB;
  logic           WLAST;
  logic           WVALID;
  logic           WREADY;
  logic [IDW-1:0] BID;
  logic [1:0]     BRESP;
  logic           BVALID;
  logic           BREADY;
  logic [IDW-1:0] ARID;
  logic [31:0]    ARADDR;
  logic [3:0]     ARLEN;
  logic           ARVALID;
  logic           ARREADY;
  logic [IDW-1:0] RID;
  logic [31:0]    RDATA;
  logic [1:0]     RRESP;
  logic           RLAST;
  logic           RVALID;
  logic           RREADY;
  logic           CS;
  logic           OE;
  logic [3:0]     WEB;
  logic [13:0]    A;
  logic [31:0]    DI;
  logic [31:0]    DO;

  always #5 clk = ~clk;

  axi_sram_slave #(.IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
  );

  typedef struct packed {
    logic [13:0] a;
    logic [3:0]  web;
    logic [31:0] di;
  } wr_ev_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    data;
    logic           last;
  } r_exp_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [1:0]     resp;
  } b_exp_t;

  logic [31:0] mem     [0:16383];
  logic [31:0] ref_mem [0:16383];
  wr_ev_t      wlog[$];
  logic [13:0] rlog[$];
  r_exp_t      r_sb[$];
  b_exp_t      b_sb[$];

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural macro: byte-masked write, read data registered one cycle after CS&OE.
  always @(posedge clk) begin
    if (CS) begin
      if (OE) begin
        DO <= mem[A];
        rlog.push_back(A);
      end else begin
        for (int b = 0; b < 4; b++)
          if (!WEB[b]) mem[A][8*b +: 8] = DI[8*b +: 8];
        wlog.push_back(wr_ev_t'{a: A, web: WEB, di: DI});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_aw(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    AWID = id; AWADDR = addr; AWLEN = len; AWVALID = 1'b1;
    #1;
    while (!AWREADY && t < TMO) begin @(negedge clk); #1; t++; end
    check("aw_ready", AWREADY, 1);
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic last);
    int t = 0;
    WDATA = d; WSTRB = s; WLAST = last; WVALID = 1'b1;
    #1;
    while (!WREADY && t < TMO) begin @(negedge clk); #1; t++; end
    check("w_ready", WREADY, 1);
    for (int b = 0; b < 4; b++)
      if (s[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    @(posedge clk); @(negedge clk);
    WVALID = 1'b0; WLAST = 1'b0;
  endtask

  task automatic recv_b();
    int t = 0;
    b_exp_t e;
    BREADY = 1'b1;
    #1;
    while (!BVALID && t < TMO) begin @(negedge clk); t++; end
    check("b_valid", BVALID, 1);
    e = b_sb.pop_front();
    check("bid", BID, e.id);
    check("bresp", BRESP, e.resp);
    @(posedge clk); @(negedge clk);
    BREADY = 1'b0;
  endtask

  task automatic send_ar(input logic [IDW-1:0] id, input logic [31:0] addr, input logic [3:0] len);
    int t = 0;
    logic [13:0] a;
    a = addr[15:2];
    for (int i = 0; i <= int'(len); i++) begin
      r_sb.push_back(r_exp_t'{id: id, data: ref_mem[a], last: (i == int'(len))});
      a = a + 14'd1;
    end
    ARID = id; ARADDR = addr; ARLEN = len; ARVALID = 1'b1;
    #1;
    while (!ARREADY && t < TMO) begin @(negedge clk); #1; t++; end
    check("ar_ready", ARREADY, 1);
    @(posedge clk); @(negedge clk);
    ARVALID = 1'b0;
  endtask

  task automatic recv_r_beat();
    int t = 0;
    r_exp_t e;
    while (!RVALID && t < TMO) begin @(negedge clk); t++; end
    check("r_valid", RVALID, 1);
    e = r_sb.pop_front();
    check("rid", RID, e.id);
    check("rdata", RDATA, e.data);
    check("rlast", RLAST, e.last);
    check("rresp", RRESP, 0);
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int rd_before;
    int wr_before;
    r_exp_t e;
    wr_ev_t w;

    for (int i = 0; i < 16384; i++) begin
      mem[i]     = 32'hA500_0000 | i;
      ref_mem[i] = 32'hA500_0000 | i;
    end
    rst = 1'b1;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARVALID = 1'b1; RREADY = 1'b0;

    // Reset state, with ARVALID held to show the ready gating.
    repeat (3) @(negedge clk);
    #1;
    check("rst_awready", AWREADY, 0);
    check("rst_arready", ARREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_cs", CS, 0);
    check("rst_oe", OE, 0);
    check("rst_web", WEB, 4'hF);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_rvalid", RVALID, 0);
    check("rst_rlast", RLAST, 0);
    check("rst_rdata", RDATA, 0);
    @(negedge clk);
    rst = 1'b0; ARVALID = 1'b0;
    #1;
    check("idle_awready", AWREADY, 1);

    // WVALID in IDLE is not accepted.
    wr_before = wlog.size();
    WVALID = 1'b1; WDATA = 32'h0BAD_0BAD; WSTRB = 4'hF;
    #1;
    check("idle_wready", WREADY, 0);
    @(negedge clk);
    WVALID = 1'b0;
    check("idle_no_write", wlog.size(), wr_before);

    // Single-beat write: id 3, addr 0x10.
    wlog.delete();
    b_sb.push_back(b_exp_t'{id: 8'd3, resp: 2'b00});
    send_aw(8'd3, 32'h0000_0010, 4'd0);
    send_w(14'h0004, 32'hDEAD_BEEF, 4'hF, 1'b1);
    check("w1_count", wlog.size(), 1);
    w = wlog.pop_front();
    check("w1_a", w.a, 14'h0004);
    check("w1_web", w.web, 4'h0);
    check("w1_di", w.di, 32'hDEAD_BEEF);
    recv_b();

    // Partial strobe write to word 8.
    b_sb.push_back(b_exp_t'{id: 8'h21, resp: 2'b00});
    send_aw(8'h21, 32'h0000_0020, 4'd0);
    send_w(14'h0008, 32'h1122_3344, 4'b0101, 1'b1);
    w = wlog.pop_front();
    check("strb_web", w.web, 4'b1010);
    recv_b();

    // Four-beat read from addr 0x10 with RREADY high.
    rlog.delete();
    RREADY = 1'b1;
    send_ar(8'd5, 32'h0000_0010, 4'd3);
    lat = 1;
    while (!RVALID && lat < TMO) begin @(negedge clk); lat++; end
    check("ar_to_rvalid", lat, 3);
    repeat (4) recv_r_beat();
    repeat (3) begin
      @(negedge clk);
      check("r4_no_extra_beat", RVALID, 0);
    end
    check("r4_reads", rlog.size(), 4);
    for (int i = 0; i < 4; i++) check("r4_addr", rlog[i], 14'h0004 + i);
    RREADY = 1'b0;

    // Simultaneous AW and AR: write first, read after B handshake.
    AWID = 8'd7; AWADDR = 32'h0000_0040; AWLEN = 4'd0; AWVALID = 1'b1;
    ARID = 8'd9; ARADDR = 32'h0000_0040; ARLEN = 4'd0; ARVALID = 1'b1;
    #1;
    check("both_awready", AWREADY, 1);
    check("both_arready", ARREADY, 0);
    @(posedge clk); @(negedge clk);
    AWVALID = 1'b0;
    #1;
    check("wr_arready", ARREADY, 0);
    b_sb.push_back(b_exp_t'{id: 8'd7, resp: 2'b00});
    send_w(14'h0010, 32'hCAFE_F00D, 4'hF, 1'b1);
    #1;
    check("brsp_arready", ARREADY, 0);
    recv_b();
    #1;
    check("post_b_arready", ARREADY, 1);
    r_sb.push_back(r_exp_t'{id: 8'd9, data: ref_mem[14'h0010], last: 1'b1});
    @(posedge clk); @(negedge clk);
    ARVALID = 1'b0;
    RREADY = 1'b1;
    recv_r_beat();
    RREADY = 1'b0;

    // Short burst (len 3, WLAST on beat 2) and overlong burst (len 0, two beats).
    b_sb.push_back(b_exp_t'{id: 8'h44, resp: 2'b10});
    send_aw(8'h44, 32'h0000_0100, 4'd3);
    send_w(14'h0040, 32'h0101_0101, 4'hF, 1'b0);
    send_w(14'h0041, 32'h0202_0202, 4'hF, 1'b1);
    recv_b();
    b_sb.push_back(b_exp_t'{id: 8'h45, resp: 2'b10});
    send_aw(8'h45, 32'h0000_0200, 4'd0);
    send_w(14'h0080, 32'h0303_0303, 4'hF, 1'b0);
    send_w(14'h0081, 32'h0404_0404, 4'hF, 1'b1);
    recv_b();

    // Address wrap at top of the 16K-word space; ignored low and high address bits.
    wlog.delete();
    b_sb.push_back(b_exp_t'{id: 8'h55, resp: 2'b00});
    send_aw(8'h55, 32'hABCD_FFFE, 4'd1);
    send_w(14'h3FFF, 32'h7777_1111, 4'hF, 1'b0);
    send_w(14'h0000, 32'h7777_2222, 4'hF, 1'b1);
    check("wrap_wcount", wlog.size(), 2);
    check("wrap_a0", wlog[0].a, 14'h3FFF);
    check("wrap_a1", wlog[1].a, 14'h0000);
    recv_b();
    rlog.delete();
    RREADY = 1'b1;
    send_ar(8'h56, 32'h1234_FFFF, 4'd1);
    repeat (2) recv_r_beat();
    check("wrap_rcount", rlog.size(), 2);
    check("wrap_ra0", rlog[0], 14'h3FFF);
    check("wrap_ra1", rlog[1], 14'h0000);
    RREADY = 1'b0;

    // Backpressure: RREADY low for 5 cycles on the first beat of a 3-beat read.
    send_ar(8'h66, 32'h0000_0010, 4'd2);
    lat = 0;
    while (!RVALID && lat < TMO) begin @(negedge clk); lat++; end
    check("stall_rvalid", RVALID, 1);
    e = r_sb.pop_front();
    rd_before = rlog.size();
    repeat (5) begin
      @(negedge clk);
      check("stall_rvalid_hold", RVALID, 1);
      check("stall_rdata", RDATA, e.data);
      check("stall_rlast", RLAST, e.last);
      check("stall_rid", RID, e.id);
      check("stall_no_read", rlog.size(), rd_before);
    end
    RREADY = 1'b1;
    @(negedge clk);
    repeat (2) recv_r_beat();
    RREADY = 1'b0;

    // Reset in the middle of a write burst.
    send_aw(8'h77, 32'h0000_0300, 4'd3);
    send_w(14'h00C0, 32'h5A5A_5A5A, 4'hF, 1'b0);
    wr_before = wlog.size();
    rst = 1'b1;
    WVALID = 1'b1; WDATA = 32'hFFFF_0000; WSTRB = 4'hF;
    #1;
    check("mid_rst_wready", WREADY, 0);
    check("mid_rst_cs", CS, 0);
    @(negedge clk);
    rst = 1'b0; WVALID = 1'b0;
    #1;
    check("post_rst_awready", AWREADY, 1);
    check("post_rst_bvalid", BVALID, 0);
    check("post_rst_rdata", RDATA, 0);
    check("post_rst_no_write", wlog.size(), wr_before);
    BREADY = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("post_rst_no_b", BVALID, 0);
    end
    BREADY = 1'b0;

    // Read back earlier writes: partial strobe, short burst, reset-abandoned burst.
    RREADY = 1'b1;
    send_ar(8'h78, 32'h0000_0020, 4'd0);
    recv_r_beat();
    send_ar(8'h79, 32'h0000_0100, 4'd1);
    repeat (2) recv_r_beat();
    send_ar(8'h7A, 32'h0000_0300, 4'd0);
    recv_r_beat();
    RREADY = 1'b0;

    check("sb_r_empty", r_sb.size(), 0);
    check("sb_b_empty", b_sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
